weight_mem_reader: RTL and testbench
====================================

Name: weight_mem_reader

Overview:
- Read-side engine for the preloaded weight memory. The memory is ROWS x COLS entries of DATA_W bits, stored row-major.
- Once preload is complete, a start pulse makes the block sweep the memory and assemble one full row of weights at a time.
- Each assembled row is offered to the PE-array weight-load port through a valid/ready handshake.
- The block sits between the weight memory read port and the systolic array weight shift-in logic.

Parameters:
- ROWS, 8, number of weight rows (PE array height)
- COLS, 8, weights per row (PE array width)
- DATA_W, 5, bits per weight
- ADDR_W, 6, memory address width; must satisfy 2^ADDR_W >= ROWS*COLS

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low (block is in reset while rst=0)
- start  input  1  one-cycle request to begin a full sweep
- preload_done  input  1  high once memory preload has finished; start is ignored while it is 0
- mem_rd_en  output  1  memory read strobe
- mem_rd_addr  output  ADDR_W  memory read address
- mem_rd_data  input  DATA_W  read data, valid the cycle after mem_rd_en
- row_valid  output  1  row_data/row_idx hold a complete row
- row_ready  input  1  consumer accepts the row when row_valid && row_ready
- row_data  output  COLS*DATA_W  row_data[c*DATA_W +: DATA_W] = weight(row, c)
- row_idx  output  clog2(ROWS)  row number carried on row_data
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; row and column counters clear.
  - mem_rd_en=0, mem_rd_addr=0, row_data=0, row_idx=0, row_valid=0, busy=0, done=0.
  - Reset mid-sweep abandons the sweep. No done pulse is produced.
- Address generation: mem_rd_addr = row*COLS + col, unsigned, truncated to ADDR_W.
- Read latency: one cycle. Data for a read issued in cycle t is sampled at the end of cycle t+1 into lane col(t).
- IDLE:
  - start && preload_done moves to FETCH with row=first row and col=0.
  - start while preload_done=0 is dropped and not remembered.
- FETCH:
  - mem_rd_en=1 every cycle; col increments each cycle.
  - Each cycle also captures the data of the previous read.
  - After the read with col=COLS-1 is issued, the next state is CAPTURE.
- CAPTURE:
  - mem_rd_en=0.
  - The last lane is captured and the state moves to PRESENT.
- PRESENT:
  - row_valid=1. row_data and row_idx stay stable until accepted.
  - On row_valid && row_ready: if this was the last row, go to DONE; otherwise advance the row, set col=0 and go to FETCH.
  - row_valid drops the cycle after acceptance.
- DONE: done=1 for exactly one cycle, then IDLE.
- Timing from a start accepted at cycle 0:
  - mem_rd_en high in cycles 1..COLS.
  - First row_valid in cycle COLS+2 (cycle 10 for defaults).
  - Each later row becomes valid COLS+2 cycles after the previous acceptance.
- Handshake corner cases:
  - row_ready while row_valid=0 is ignored.
  - row_ready held permanently high gives back-to-back sweeps with no extra bubbles.
  - Backpressure (row_ready=0) freezes all state; no memory reads occur while waiting.
- start while busy=1 is ignored; a sweep in progress is never restarted.
- A start arriving in the DONE cycle is ignored.
- Counter wrap: col wraps COLS-1 -> 0 only on a row change. The row counter never wraps within a sweep.

Optional Feature:
- Macro: WEIGHT_ROW_REVERSE_EN.
- Defined: rows are emitted in order ROWS-1 down to 0, so the bottom row enters the systolic array first. row_idx carries the true row number. The last row of the sweep is row 0.
- Undefined: rows are emitted in order 0 up to ROWS-1. The last row of the sweep is ROWS-1.
- Column order within a row and the lane packing are identical in both builds.

Test Plan:
- Memory model with mem[a] = a mod 32, preload_done=1, start pulse, row_ready tied to 1:
  - Rows arrive with row_idx 0..7.
  - Row 0 lanes are 0..7; row 5 lanes are 8..15 (addresses 40..47 mod 32).
  - done pulses once, 8*10+1 cycles after start.
- start pulsed with preload_done=0 -> busy, mem_rd_en and row_valid stay 0; a later start with preload_done=1 runs a normal sweep.
- row_ready held low for 20 cycles while row 2 is presented:
  - row_valid, row_data and row_idx remain stable; mem_rd_en stays 0.
  - Raising row_ready for 1 cycle accepts the row; row 3 appears 10 cycles later.
- Second start pulsed at cycle 30 of a sweep -> ignored; exactly 8 rows and one done pulse.
- rst driven low during FETCH of row 4 -> all outputs return to reset values asynchronously; no done pulse; a fresh start restarts from the first row.
- Build with WEIGHT_ROW_REVERSE_EN -> row_idx sequence is 7..0; the row 7 lanes read addresses 56..63 (values 24..31 under mem[a] = a mod 32); done follows acceptance of row 0.

Source files
------------

// File: rtl/weight_mem_reader.sv
// weight_mem_reader: sweeps the preloaded weight memory one row at a time,
// assembles each row into COLS lanes and offers it to the PE-array weight
// load port with a valid/ready handshake.
// Optional build macro WEIGHT_ROW_REVERSE_EN: rows are emitted ROWS-1 down to 0
// instead of 0 up to ROWS-1. Lane packing and column order are unchanged.

// One weight lane: loads the memory read data when its column is captured.
module weight_mem_reader_lane #(
    parameter int DATA_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q
);
    // Hold the lane value until this column is read again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     q <= '0;
        else if (cap) q <= din;
    end
endmodule

module weight_mem_reader #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 5,
    parameter int ADDR_W = 6,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   preload_done,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_rd_addr,
    input  logic [DATA_W-1:0]      mem_rd_data,
    output logic                   row_valid,
    input  logic                   row_ready,
    output logic [COLS*DATA_W-1:0] row_data,
    output logic [RW-1:0]          row_idx,
    output logic                   busy,
    output logic                   done
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH   = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] PRESENT = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]    state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [RW-1:0] row_idx_q;
    logic          last_row;
    logic [RW-1:0] next_row;
    logic          cap_vld;    // a read was issued last cycle
    logic [CW-1:0] cap_lane;   // lane that read belongs to
    logic [COLS-1:0]             lane_cap;
    logic [COLS-1:0][DATA_W-1:0] lanes;

`ifdef WEIGHT_ROW_REVERSE_EN
    localparam logic [RW-1:0] FIRST_ROW = RW'(ROWS - 1);
    assign last_row = (row == '0);
    assign next_row = row - RW'(1);
`else
    localparam logic [RW-1:0] FIRST_ROW = '0;
    assign last_row = (row == RW'(ROWS - 1));
    assign next_row = row + RW'(1);
`endif

    assign mem_rd_en   = (state == FETCH);
    assign mem_rd_addr = mem_rd_en ? (ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col)) : '0;
    assign row_valid   = (state == PRESENT);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign row_idx     = row_idx_q;
    assign row_data    = lanes;

    // Sweep control: fetch a row, capture its last lane, present, advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            row_idx_q <= '0;
        end else begin
            case (state)
                IDLE: if (start && preload_done) begin
                    state <= FETCH;
                    row   <= FIRST_ROW;
                    col   <= '0;
                end
                FETCH: begin
                    // col parks at COLS-1; it only wraps on a row change
                    if (col == CW'(COLS - 1)) state <= CAPTURE;
                    else                      col   <= col + CW'(1);
                end
                CAPTURE: begin
                    state     <= PRESENT;
                    row_idx_q <= row;
                end
                PRESENT: if (row_ready) begin
                    if (last_row) begin
                        state <= DONE;
                    end else begin
                        state <= FETCH;
                        row   <= next_row;
                        col   <= '0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read data returns one cycle late; remember which lane it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_vld  <= 1'b0;
            cap_lane <= '0;
        end else begin
            cap_vld  <= mem_rd_en;
            cap_lane <= col;
        end
    end

    for (genvar i = 0; i < COLS; i++) begin : g_lane
        assign lane_cap[i] = cap_vld && (cap_lane == CW'(i));
        weight_mem_reader_lane #(.DATA_W(DATA_W)) u_lane (
            .clk (clk),
            .rst (rst),
            .cap (lane_cap[i]),
            .din (mem_rd_data),
            .q   (lanes[i])
        );
    end
endmodule

// File: tb/tb_weight_mem_reader.sv
// Bench for weight_mem_reader: memory model, acceptance monitor and one task
// per scenario; expectations come from row/column arithmetic on the memory.
module tb_weight_mem_reader;
    localparam int ROWS = 8, COLS = 8, DATA_W = 5, ADDR_W = 6, RW = 3;
    localparam int RD = COLS * DATA_W;

    logic clk = 0, rst = 0, start = 0, preload_done = 0, row_ready = 0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              row_valid, busy, done;
    logic [RD-1:0]     row_data;
    logic [RW-1:0]     row_idx;

    weight_mem_reader #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .preload_done(preload_done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_idx(row_idx), .busy(busy), .done(done));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory: one-cycle read latency
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    // monitor of accepted rows, done pulses and reads
    int            acc_idx[$];
    logic [RD-1:0] acc_data[$];
    int            acc_cyc[$];
    int            done_cyc[$];
    int            rd_cnt = 0, rd_bad = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (row_valid && row_ready) begin
                acc_idx.push_back(int'(row_idx));
                acc_data.push_back(row_data);
                acc_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            if (mem_rd_en) rd_cnt++;
            if (mem_rd_en && row_valid) rd_bad++;
        end
    end

    task automatic clear_mon();
        acc_idx.delete(); acc_data.delete(); acc_cyc.delete(); done_cyc.delete();
        rd_cnt = 0; rd_bad = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(output int t0);
        step(); start = 1; t0 = cyc;
        step(); start = 0;
    endtask

    // k-th row of a sweep in emission order
    function automatic int exp_idx(int k);
`ifdef WEIGHT_ROW_REVERSE_EN
        return ROWS - 1 - k;
`else
        return k;
`endif
    endfunction

    function automatic logic [RD-1:0] exp_row(int r);
        logic [RD-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*DATA_W +: DATA_W] = mem[r*COLS + c];
        return v;
    endfunction

    function automatic logic [RD-1:0] mod32_row(int r);
        logic [RD-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*DATA_W +: DATA_W] = DATA_W'((r*COLS + c) % 32);
        return v;
    endfunction

    task automatic fill_mod32();
        for (int a = 0; a < (1<<ADDR_W); a++) mem[a] = DATA_W'(a % 32);
    endtask

    task automatic fill_random();
        for (int a = 0; a < (1<<ADDR_W); a++) mem[a] = DATA_W'($urandom);
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
        n_tests++; if (mem_rd_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", mem_rd_addr); end
        n_tests++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", row_valid); end
        n_tests++; if (row_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", row_data); end
        n_tests++; if (row_idx !== '0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", row_idx); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        step(); rst = 1; step();
    endtask

    task automatic test_sweep_mod32();
        int t0;
        fill_mod32(); preload_done = 1; row_ready = 1; clear_mon();
        pulse_start(t0);
        repeat (90) step();
        n_tests++; if (acc_idx.size() != ROWS) begin n_fail++; $display("FAIL sweep_rows got %0d want %0d", acc_idx.size(), ROWS); end
        for (int k = 0; k < ROWS && k < acc_idx.size(); k++) begin
            n_tests++; if (acc_idx[k] != exp_idx(k)) begin n_fail++; $display("FAIL sweep_idx k=%0d got %0d want %0d", k, acc_idx[k], exp_idx(k)); end
            n_tests++; if (acc_data[k] !== mod32_row(exp_idx(k))) begin n_fail++; $display("FAIL sweep_data k=%0d got %h want %h", k, acc_data[k], mod32_row(exp_idx(k))); end
            n_tests++; if (acc_cyc[k] != t0 + (COLS+2)*(k+1)) begin n_fail++; $display("FAIL sweep_time k=%0d got %0d want %0d", k, acc_cyc[k]-t0, (COLS+2)*(k+1)); end
        end
        n_tests++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL sweep_done_cnt got %0d want 1", done_cyc.size()); end
        else begin
            n_tests++; if (done_cyc[0] != t0 + ROWS*(COLS+2) + 1) begin n_fail++; $display("FAIL sweep_done_time got %0d want %0d", done_cyc[0]-t0, ROWS*(COLS+2)+1); end
        end
        n_tests++; if (rd_cnt != ROWS*COLS) begin n_fail++; $display("FAIL sweep_reads got %0d want %0d", rd_cnt, ROWS*COLS); end
    endtask

    task automatic test_no_preload_then_random_ready();
        int t0, w;
        preload_done = 0; row_ready = 1; clear_mon();
        pulse_start(t0);
        repeat (15) begin
            @(negedge clk);
            n_tests++; if ({busy, mem_rd_en, row_valid} !== 3'b000) begin n_fail++; $display("FAIL nopre_idle got %b want 000", {busy, mem_rd_en, row_valid}); end
        end
        fill_random(); preload_done = 1; clear_mon();
        pulse_start(t0);
        w = 0;
        while (done_cyc.size() == 0 && w < 3000) begin
            row_ready = $urandom_range(0, 1) == 1;
            step(); w++;
        end
        row_ready = 0;
        n_tests++; if (done_cyc.size() == 0) begin n_fail++; $display("FAIL rand_timeout got no done want done"); end
        repeat (5) step();
        n_tests++; if (acc_idx.size() != ROWS) begin n_fail++; $display("FAIL rand_rows got %0d want %0d", acc_idx.size(), ROWS); end
        for (int k = 0; k < ROWS && k < acc_idx.size(); k++) begin
            n_tests++; if (acc_idx[k] != exp_idx(k)) begin n_fail++; $display("FAIL rand_idx k=%0d got %0d want %0d", k, acc_idx[k], exp_idx(k)); end
            n_tests++; if (acc_data[k] !== exp_row(exp_idx(k))) begin n_fail++; $display("FAIL rand_data k=%0d got %h want %h", k, acc_data[k], exp_row(exp_idx(k))); end
        end
        n_tests++; if (rd_cnt != ROWS*COLS) begin n_fail++; $display("FAIL rand_reads got %0d want %0d", rd_cnt, ROWS*COLS); end
        n_tests++; if (rd_bad != 0) begin n_fail++; $display("FAIL rand_read_while_valid got %0d want 0", rd_bad); end
        n_tests++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL rand_done_cnt got %0d want 1", done_cyc.size()); end
        else if (acc_cyc.size() == ROWS) begin
            n_tests++; if (done_cyc[0] != acc_cyc[ROWS-1] + 1) begin n_fail++; $display("FAIL rand_done_time got %0d want %0d", done_cyc[0], acc_cyc[ROWS-1]+1); end
        end
    endtask

    task automatic test_backpressure();
        int t0, last, w, vcyc;
        logic [RD-1:0] sd;
        logic [RW-1:0] si;
        fill_random(); row_ready = 0; clear_mon();
        pulse_start(t0);
        last = t0;
        for (int k = 0; k < ROWS; k++) begin
            w = 0;
            do begin @(negedge clk); w++; end while (!row_valid && w < 50);
            vcyc = cyc;
            n_tests++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout k=%0d got no valid want valid", k); end
            n_tests++; if (vcyc != last + COLS + 2) begin n_fail++; $display("FAIL bp_latency k=%0d got %0d want %0d", k, vcyc-last, COLS+2); end
            n_tests++; if (row_idx !== RW'(exp_idx(k))) begin n_fail++; $display("FAIL bp_idx k=%0d got %0d want %0d", k, row_idx, exp_idx(k)); end
            n_tests++; if (row_data !== exp_row(exp_idx(k))) begin n_fail++; $display("FAIL bp_data k=%0d got %h want %h", k, row_data, exp_row(exp_idx(k))); end
            if (k == 2) begin
                sd = exp_row(exp_idx(k)); si = RW'(exp_idx(k));
                repeat (20) begin
                    @(negedge clk);
                    n_tests++; if ({row_valid, mem_rd_en, row_idx, row_data} !== {1'b1, 1'b0, si, sd}) begin
                        n_fail++; $display("FAIL bp_hold got v=%b rd=%b idx=%0d data=%h want v=1 rd=0 idx=%0d data=%h",
                                           row_valid, mem_rd_en, row_idx, row_data, si, sd);
                    end
                end
            end
            step(); row_ready = 1; last = cyc;
            step(); row_ready = 0;
        end
        repeat (4) step();
        n_tests++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL bp_done_cnt got %0d want 1", done_cyc.size()); end
        else begin
            n_tests++; if (done_cyc[0] != last + 1) begin n_fail++; $display("FAIL bp_done_time got %0d want %0d", done_cyc[0], last+1); end
        end
        n_tests++; if (rd_bad != 0) begin n_fail++; $display("FAIL bp_read_while_valid got %0d want 0", rd_bad); end
    endtask

    task automatic test_restart_ignored();
        int t0;
        fill_mod32(); row_ready = 1; clear_mon();
        pulse_start(t0);
        while (cyc < t0 + 30) step();
        start = 1; step(); start = 0;
        // start landing exactly in the DONE cycle
        while (cyc < t0 + ROWS*(COLS+2) + 1) step();
        start = 1; step(); start = 0;
        repeat (20) step();
        n_tests++; if (acc_idx.size() != ROWS) begin n_fail++; $display("FAIL restart_rows got %0d want %0d", acc_idx.size(), ROWS); end
        n_tests++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL restart_done_cnt got %0d want 1", done_cyc.size()); end
        else begin
            n_tests++; if (done_cyc[0] != t0 + ROWS*(COLS+2) + 1) begin n_fail++; $display("FAIL restart_done_time got %0d want %0d", done_cyc[0]-t0, ROWS*(COLS+2)+1); end
        end
        n_tests++; if (rd_cnt != ROWS*COLS) begin n_fail++; $display("FAIL restart_reads got %0d want %0d", rd_cnt, ROWS*COLS); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_busy got %b want 0", busy); end
    endtask

    task automatic test_midsweep_reset();
        int t0;
        fill_random(); row_ready = 1; clear_mon();
        pulse_start(t0);
        // fifth row of the sweep is in FETCH during cycles t0+41..t0+48
        while (cyc < t0 + 4*(COLS+2) + 4) step();
        n_tests++; if ({busy, mem_rd_en} !== 2'b11) begin n_fail++; $display("FAIL mid_fetch got %b want 11", {busy, mem_rd_en}); end
        rst = 0; #1;
        n_tests++; if ({busy, mem_rd_en, mem_rd_addr, row_valid, row_data, row_idx, done} !== '0) begin
            n_fail++; $display("FAIL mid_async_reset got busy=%b rd=%b addr=%0d v=%b data=%h idx=%0d done=%b want all 0",
                               busy, mem_rd_en, mem_rd_addr, row_valid, row_data, row_idx, done);
        end
        repeat (3) step();
        rst = 1; step();
        n_tests++; if (acc_idx.size() != 4) begin n_fail++; $display("FAIL mid_rows_before got %0d want 4", acc_idx.size()); end
        n_tests++; if (done_cyc.size() != 0) begin n_fail++; $display("FAIL mid_done_after_reset got %0d want 0", done_cyc.size()); end
        clear_mon();
        pulse_start(t0);
        repeat (90) step();
        n_tests++; if (acc_idx.size() != ROWS) begin n_fail++; $display("FAIL mid_fresh_rows got %0d want %0d", acc_idx.size(), ROWS); end
        else begin
            n_tests++; if (acc_idx[0] != exp_idx(0)) begin n_fail++; $display("FAIL mid_fresh_first got %0d want %0d", acc_idx[0], exp_idx(0)); end
            n_tests++; if (acc_data[0] !== exp_row(exp_idx(0))) begin n_fail++; $display("FAIL mid_fresh_data got %h want %h", acc_data[0], exp_row(exp_idx(0))); end
        end
        n_tests++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL mid_fresh_done got %0d want 1", done_cyc.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sweep_mod32();
        test_no_preload_then_random_ready();
        test_backpressure();
        test_restart_ignored();
        test_midsweep_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
